jump_phase_sequencer: RTL and testbench
=======================================

Name: jump_phase_sequencer

Overview:
Owns the four-phase instruction cycle (FETCH, DECODE, EXECUTE, COMMIT) that drives the jump, load/store, ALU and system group decoders. It accepts memory wait states, evaluates the condition-code decision for jump-group instructions, and issues the single program-counter update per instruction. It also handles HALT entry and exit, and a bus-timeout error.

Parameters:
WAIT_LIMIT, 15, max consecutive wait cycles in FETCH/EXECUTE before BUS_ERROR; 0 disables timeout
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
PC_EN  in  1  from decoders; 0 when current instruction is HALT
JMPX  in  1  current instruction is jump group
CC_APPLYX  in  1  jump is conditional
CC_INVERTX  in  1  invert selected condition
CC_SELECTX  in  2  condition select: 0 Z, 1 C, 2 S, 3 V
FLAGS  in  4  {V,S,C,Z} from ALU flag register
MEM_REQX  in  1  decoded instruction needs memory in EXECUTE
MEM_READY  in  1  memory completes access this cycle
RESUME  in  1  leave HALT
FETCH  out  1  phase strobe, one-hot with the other three
DECODE  out  1  phase strobe
EXECUTE  out  1  phase strobe
COMMIT  out  1  phase strobe
PC_LOAD  out  1  load PC from jump target (COMMIT only)
PC_INC  out  1  increment PC (COMMIT only)
HALTED  out  1  sequencer in HALT
BUS_ERROR  out  1  sticky wait-timeout flag
INSTR_COUNT  out  CNT_W  retired-instruction count

Behaviour:
- Interface: one clock CLK; reset RESET is synchronous and active-high.
- Reset: state=FETCH. FETCH=1. All other strobes, PC_LOAD, PC_INC, HALTED and BUS_ERROR are 0. INSTR_COUNT=0. Wait counter=0. take_q=0.
- States: FETCH, DECODE, EXECUTE, COMMIT, HALT. All outputs are decoded from registered state or registered flags; no input-to-output combinational path.
- FETCH: stays while MEM_READY=0; moves to DECODE on the cycle MEM_READY=1.
- DECODE: one cycle. If PC_EN=0, go to HALT; otherwise go to EXECUTE.
- EXECUTE:
  - If MEM_REQX=1, stay until MEM_READY=1; otherwise one cycle.
  - On exit, latch take_q = JMPX & (~CC_APPLYX | (FLAGS[CC_SELECTX] ^ CC_INVERTX)), using FLAGS sampled on that exit cycle.
- COMMIT: one cycle.
  - PC_LOAD = take_q; PC_INC = ~take_q. Exactly one of the two is high.
  - INSTR_COUNT increments, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- HALT:
  - HALTED=1; no strobes; PC unchanged.
  - RESUME=1 moves to COMMIT with take_q forced 0, so the PC steps past the HALT and the instruction is counted.
  - RESUME held high while already in COMMIT has no effect.
- Wait counter:
  - Increments each FETCH/EXECUTE cycle spent waiting. Clears on phase exit.
  - If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT with MEM_READY still 0: set BUS_ERROR and go to HALT.
  - BUS_ERROR clears only on RESET.
  - RESUME while BUS_ERROR=1 is ignored.
- Simultaneous events:
  - RESET overrides everything.
  - MEM_READY arriving on the timeout cycle counts as success: no error.
- Reset mid-wait abandons the access; next cycle is FETCH.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined:
  - Adds inputs STEP_MODE (1) and STEP (1), and state STEP_WAIT.
  - When STEP_MODE=1, COMMIT goes to STEP_WAIT. STEP_WAIT has no strobes and HALTED=0.
  - A STEP=1 cycle moves STEP_WAIT to FETCH.
  - STEP_MODE sampled 0 in STEP_WAIT also exits to FETCH.
- Undefined: the ports and state are absent; COMMIT always goes to FETCH.

Decomposition:
- Shared constants header (existing constants file): phase/state encodings, CC_SELECT index constants (CC_Z=0, CC_C=1, CC_S=2, CC_V=3).
- One natural sub-module, cc_evaluator: combinational take decision from JMPX, CC_* and FLAGS. Reused by any skip logic.
- The FSM, wait counter and INSTR_COUNT stay in jump_phase_sequencer.

Test Plan:
1. Straight-line ALU op, MEM_READY=1 always, JMPX=0 -> strobes F,D,E,C on 4 consecutive cycles; PC_INC=1 on cycle 4; INSTR_COUNT 0->1.
2. Conditional jump JMPX=1, CC_APPLYX=1, CC_INVERTX=0, CC_SELECTX=0, FLAGS=4'b0001 -> PC_LOAD=1, PC_INC=0 in COMMIT. Repeat with FLAGS=0 -> PC_INC=1. Repeat with CC_INVERTX=1, FLAGS=0 -> PC_LOAD=1.
3. FETCH with MEM_READY low 3 cycles -> FETCH held 4 cycles, then DECODE. With MEM_REQX=1 and 2 waits -> EXECUTE held 3 cycles.
4. PC_EN=0 in DECODE -> HALT, HALTED=1, no strobes for 10 cycles. RESUME pulse -> COMMIT with PC_INC=1, then FETCH; INSTR_COUNT +1.
5. WAIT_LIMIT=4, MEM_READY stuck 0 in FETCH -> BUS_ERROR=1 and HALT after 4 wait cycles. RESUME ignored. RESET clears BUS_ERROR and returns to FETCH.
6. RESET asserted mid-EXECUTE wait -> next cycle FETCH=1 and all other outputs 0. CNT_W=4 with 16 retirements -> INSTR_COUNT wraps to 0.

Source files
------------

// File: rtl/jump_phase_sequencer_pkg.sv
// Shared encodings for the jump phase sequencer: phase states, condition-code selects, output bundle.
// SEQ_SINGLE_STEP_EN adds the STEP_WAIT state.
package jump_phase_sequencer_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned CC_SEL_W = 2;
    localparam int unsigned FLAGS_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_HALT      = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
        ,
        ST_STEP_WAIT = 3'd5
`endif
    } seq_state_e;

    localparam logic [CC_SEL_W-1:0] CC_Z = 2'd0;
    localparam logic [CC_SEL_W-1:0] CC_C = 2'd1;
    localparam logic [CC_SEL_W-1:0] CC_S = 2'd2;
    localparam logic [CC_SEL_W-1:0] CC_V = 2'd3;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic execute;
        logic commit;
        logic pc_load;
        logic pc_inc;
        logic halted;
    } seq_out_t;

    // FLAGS is packed {V,S,C,Z}
    function automatic logic cc_flag(input logic [FLAGS_W-1:0] flags,
                                     input logic [CC_SEL_W-1:0] sel);
        logic f;
        f = flags[0];
        unique case (sel)
            CC_Z: f = flags[0];
            CC_C: f = flags[1];
            CC_S: f = flags[2];
            CC_V: f = flags[3];
            default: f = flags[0];
        endcase
        return f;
    endfunction

endpackage

// File: rtl/jump_phase_sequencer_cc_evaluator.sv
// Combinational take decision for jump-group instructions from the condition-code controls.
module jump_phase_sequencer_cc_evaluator
    import jump_phase_sequencer_pkg::*;
(
    input  logic                jmp,
    input  logic                cc_apply,
    input  logic                cc_invert,
    input  logic [CC_SEL_W-1:0] cc_select,
    input  logic [FLAGS_W-1:0]  flags,
    output logic                take_c
);

    assign take_c = jmp & (~cc_apply | (cc_flag(flags, cc_select) ^ cc_invert));

endmodule

// File: rtl/jump_phase_sequencer.sv
// Four-phase instruction sequencer with wait states, HALT handling, bus timeout and retire counter.
// Optional single-step mode is enabled with SEQ_SINGLE_STEP_EN.
module jump_phase_sequencer
    import jump_phase_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PC_EN,
    input  logic                JMPX,
    input  logic                CC_APPLYX,
    input  logic                CC_INVERTX,
    input  logic [CC_SEL_W-1:0] CC_SELECTX,
    input  logic [FLAGS_W-1:0]  FLAGS,
    input  logic                MEM_REQX,
    input  logic                MEM_READY,
    input  logic                RESUME,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                STEP_MODE,
    input  logic                STEP,
`endif
    output logic                FETCH,
    output logic                DECODE,
    output logic                EXECUTE,
    output logic                COMMIT,
    output logic                PC_LOAD,
    output logic                PC_INC,
    output logic                HALTED,
    output logic                BUS_ERROR,
    output logic [CNT_W-1:0]    INSTR_COUNT
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    seq_state_e        state_q, state_d;
    seq_out_t          out_q, out_d;
    logic              take_q, take_d;
    logic              bus_error_q, bus_error_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cc_take_c;
    logic              wait_hit_c;

    jump_phase_sequencer_cc_evaluator u_cc_eval (
        .jmp       (JMPX),
        .cc_apply  (CC_APPLYX),
        .cc_invert (CC_INVERTX),
        .cc_select (CC_SELECTX),
        .flags     (FLAGS),
        .take_c    (cc_take_c)
    );

    // A waiting cycle times out when it would be the WAIT_LIMIT-th consecutive wait
    assign wait_hit_c = (WAIT_LIMIT != 0) && ((32'(wait_cnt_q) + 32'd1) == WAIT_LIMIT);

    always_comb begin
        state_d     = state_q;
        take_d      = take_q;
        bus_error_d = bus_error_q;
        wait_cnt_d  = wait_cnt_q;
        count_d     = count_q;
        out_d       = '0;

        unique case (state_q)
            ST_FETCH: begin
                if (MEM_READY) begin
                    state_d    = ST_DECODE;
                    wait_cnt_d = '0;
                end else if (wait_hit_c) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                state_d = PC_EN ? ST_EXECUTE : ST_HALT;
            end
            ST_EXECUTE: begin
                if (!MEM_REQX || MEM_READY) begin
                    state_d    = ST_COMMIT;
                    take_d     = cc_take_c;
                    wait_cnt_d = '0;
                end else if (wait_hit_c) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_COMMIT: begin
                count_d = count_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                state_d = STEP_MODE ? ST_STEP_WAIT : ST_FETCH;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_HALT: begin
                // Resuming retires the HALT itself: step the PC, never load it
                if (RESUME && !bus_error_q) begin
                    state_d = ST_COMMIT;
                    take_d  = 1'b0;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (STEP || !STEP_MODE) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Outputs are registered copies of the next-state decode
        out_d.fetch   = (state_d == ST_FETCH);
        out_d.decode  = (state_d == ST_DECODE);
        out_d.execute = (state_d == ST_EXECUTE);
        out_d.commit  = (state_d == ST_COMMIT);
        out_d.pc_load = (state_d == ST_COMMIT) &  take_d;
        out_d.pc_inc  = (state_d == ST_COMMIT) & ~take_d;
        out_d.halted  = (state_d == ST_HALT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_FETCH;
            out_q         <= '0;
            out_q.fetch   <= 1'b1;
            take_q        <= 1'b0;
            bus_error_q   <= 1'b0;
            wait_cnt_q    <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            out_q         <= out_d;
            take_q        <= take_d;
            bus_error_q   <= bus_error_d;
            wait_cnt_q    <= wait_cnt_d;
            count_q       <= count_d;
        end
    end

    assign FETCH       = out_q.fetch;
    assign DECODE      = out_q.decode;
    assign EXECUTE     = out_q.execute;
    assign COMMIT      = out_q.commit;
    assign PC_LOAD     = out_q.pc_load;
    assign PC_INC      = out_q.pc_inc;
    assign HALTED      = out_q.halted;
    assign BUS_ERROR   = bus_error_q;
    assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_jump_phase_sequencer.sv
// Directed self-checking bench for jump_phase_sequencer (WAIT_LIMIT=4, CNT_W=4).
module tb_jump_phase_sequencer;

    localparam int unsigned WAIT_LIMIT = 4;
    localparam int unsigned CNT_W      = 4;

    // {FETCH,DECODE,EXECUTE,COMMIT,PC_LOAD,PC_INC,HALTED,BUS_ERROR}
    localparam logic [7:0] O_F      = 8'b1000_0000;
    localparam logic [7:0] O_D      = 8'b0100_0000;
    localparam logic [7:0] O_E      = 8'b0010_0000;
    localparam logic [7:0] O_C_INC  = 8'b0001_0100;
    localparam logic [7:0] O_C_LD   = 8'b0001_1000;
    localparam logic [7:0] O_H      = 8'b0000_0010;
    localparam logic [7:0] O_H_ERR  = 8'b0000_0011;

    logic             clk;
    logic             reset;
    logic             pc_en;
    logic             jmpx;
    logic             cc_applyx;
    logic             cc_invertx;
    logic [1:0]       cc_selectx;
    logic [3:0]       flags;
    logic             mem_reqx;
    logic             mem_ready;
    logic             resume;
    logic             fetch_o, decode_o, execute_o, commit_o;
    logic             pc_load_o, pc_inc_o, halted_o, bus_error_o;
    logic [CNT_W-1:0] instr_count_o;
    logic [7:0]       outs;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    jump_phase_sequencer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK         (clk),
        .RESET       (reset),
        .PC_EN       (pc_en),
        .JMPX        (jmpx),
        .CC_APPLYX   (cc_applyx),
        .CC_INVERTX  (cc_invertx),
        .CC_SELECTX  (cc_selectx),
        .FLAGS       (flags),
        .MEM_REQX    (mem_reqx),
        .MEM_READY   (mem_ready),
        .RESUME      (resume),
`ifdef SEQ_SINGLE_STEP_EN
        .STEP_MODE   (1'b0),
        .STEP        (1'b0),
`endif
        .FETCH       (fetch_o),
        .DECODE      (decode_o),
        .EXECUTE     (execute_o),
        .COMMIT      (commit_o),
        .PC_LOAD     (pc_load_o),
        .PC_INC      (pc_inc_o),
        .HALTED      (halted_o),
        .BUS_ERROR   (bus_error_o),
        .INSTR_COUNT (instr_count_o)
    );

    assign outs = {fetch_o, decode_o, execute_o, commit_o, pc_load_o, pc_inc_o, halted_o, bus_error_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with MEM_READY=1: run one instruction through COMMIT back to FETCH
    task automatic run_instr(input string tag, input logic jmp, input logic apply,
                             input logic inv, input logic [1:0] sel, input logic [3:0] fl,
                             input logic take);
        jmpx = jmp; cc_applyx = apply; cc_invertx = inv; cc_selectx = sel; flags = fl;
        tick();
        tick();
        tick();
        check({tag, "_commit"}, 32'(outs), 32'(take ? O_C_LD : O_C_INC));
        tick();
        exp_cnt = (exp_cnt + 1) % 16;
        check({tag, "_count"}, 32'(instr_count_o), 32'(exp_cnt));
        jmpx = 1'b0; cc_applyx = 1'b0; cc_invertx = 1'b0; cc_selectx = 2'd0; flags = 4'd0;
    endtask

    initial begin
        reset = 1'b1; pc_en = 1'b1; jmpx = 1'b0; cc_applyx = 1'b0; cc_invertx = 1'b0;
        cc_selectx = 2'd0; flags = 4'd0; mem_reqx = 1'b0; mem_ready = 1'b1; resume = 1'b0;
        tick();
        tick();
        check("reset_outs", 32'(outs), 32'(O_F));
        check("reset_count", 32'(instr_count_o), 32'd0);
        reset = 1'b0;

        // Straight-line ALU instruction
        tick();
        check("t1_decode", 32'(outs), 32'(O_D));
        tick();
        check("t1_execute", 32'(outs), 32'(O_E));
        tick();
        check("t1_commit", 32'(outs), 32'(O_C_INC));
        check("t1_count_pre", 32'(instr_count_o), 32'd0);
        tick();
        exp_cnt = 1;
        check("t1_fetch", 32'(outs), 32'(O_F));
        check("t1_count", 32'(instr_count_o), 32'd1);

        // FETCH wait states: ready arrives on the cycle that would have timed out
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_fetch_hold", 32'(outs), 32'(O_F));
        end
        mem_ready = 1'b1;
        tick();
        check("t3_fetch_exit", 32'(outs), 32'(O_D));
        mem_reqx = 1'b1;
        mem_ready = 1'b0;
        tick();
        check("t3_exec_1", 32'(outs), 32'(O_E));
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t3_exec_hold", 32'(outs), 32'(O_E));
        end
        mem_ready = 1'b1;
        tick();
        check("t3_exec_commit", 32'(outs), 32'(O_C_INC));
        tick();
        mem_reqx = 1'b0;
        exp_cnt = 2;
        check("t3_fetch", 32'(outs), 32'(O_F));
        check("t3_count", 32'(instr_count_o), 32'd2);

        // Condition-code decisions
        run_instr("t2_z_set",    1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1);
        run_instr("t2_z_clr",    1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        run_instr("t2_z_inv",    1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
        run_instr("t2_c_set",    1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1);
        run_instr("t2_s_clr",    1'b1, 1'b1, 1'b0, 2'd2, 4'b1011, 1'b0);
        run_instr("t2_v_inv",    1'b1, 1'b1, 1'b1, 2'd3, 4'b1111, 1'b0);
        run_instr("t2_nojmp",    1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        run_instr("t2_uncond",   1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);

        // HALT right after a taken jump; resume must still increment
        pc_en = 1'b0;
        tick();
        check("t4_decode", 32'(outs), 32'(O_D));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_halt", 32'(outs), 32'(O_H));
        end
        check("t4_count_halt", 32'(instr_count_o), 32'(exp_cnt));
        resume = 1'b1;
        pc_en = 1'b1;
        tick();
        check("t4_resume_commit", 32'(outs), 32'(O_C_INC));
        tick();
        exp_cnt = (exp_cnt + 1) % 16;
        check("t4_fetch", 32'(outs), 32'(O_F));
        check("t4_count", 32'(instr_count_o), 32'(exp_cnt));
        resume = 1'b0;

        // Bus timeout in FETCH after WAIT_LIMIT waits
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_fetch_wait", 32'(outs), 32'(O_F));
        end
        tick();
        check("t5_timeout", 32'(outs), 32'(O_H_ERR));
        resume = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_resume_ignored", 32'(outs), 32'(O_H_ERR));
        end
        resume = 1'b0;
        reset = 1'b1;
        tick();
        exp_cnt = 0;
        check("t5_reset", 32'(outs), 32'(O_F));
        check("t5_reset_count", 32'(instr_count_o), 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;

        // Reset in the middle of an EXECUTE wait
        run_instr("t6_pre", 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        tick();
        mem_reqx = 1'b1;
        mem_ready = 1'b0;
        tick();
        check("t6_exec", 32'(outs), 32'(O_E));
        tick();
        check("t6_exec_wait", 32'(outs), 32'(O_E));
        reset = 1'b1;
        tick();
        exp_cnt = 0;
        check("t6_reset_outs", 32'(outs), 32'(O_F));
        check("t6_reset_count", 32'(instr_count_o), 32'd0);
        reset = 1'b0;
        mem_reqx = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("t6_after_reset", 32'(outs), 32'(O_D));
        tick();
        tick();
        tick();
        exp_cnt = 1;
        check("t6_count1", 32'(instr_count_o), 32'd1);

        // Counter wrap: 15 more retirements reach 0 modulo 16
        for (int i = 0; i < 15; i++) begin
            run_instr("t6_wrap", 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        end
        check("t6_wrapped", 32'(instr_count_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
